// File: rtl/sys_array_result_drain_if.sv
// Output stream bundle for sys_array_result_drain.
//   m_valid  : beat valid (driven by master)
//   m_ready  : consumer accepts beat (driven by slave)
//   m_data   : element value, 2*DATA_WIDTH bits
//   m_row    : row index of the current beat
//   m_col    : column index of the current beat
//   m_last   : current beat is element (W-1, W-1)
interface sys_array_result_drain_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ARRAY_W    = 5
);
    localparam int IDX_W = $clog2(ARRAY_W);

    logic                    m_valid;
    logic                    m_ready;
    logic [2*DATA_WIDTH-1:0] m_data;
    logic [IDX_W-1:0]        m_row;
    logic [IDX_W-1:0]        m_col;
    logic                    m_last;

    modport master (
        output m_valid, m_data, m_row, m_col, m_last,
        input  m_ready
    );

    modport slave (
        input  m_valid, m_data, m_row, m_col, m_last,
        output m_ready
    );
endinterface

// File: rtl/sys_array_result_drain.sv
// Captures the ARRAY_W x ARRAY_W result matrix from sys_array_fetcher on a
// rising edge of res_ready and streams it out row-major, one element per
// valid/ready beat, tagged with (row, col, last).
//   clk        : clock, rising edge
//   reset_n    : asynchronous reset, active low
//   res_ready  : fetcher ready level; its rising edge marks a new result
//   res_data   : fetcher result matrix, sampled only at the capture edge
//   stream     : master side of the output beat stream
//   busy       : high while streaming
//   overrun    : sticky, a new result arrived while the previous was still streaming
module sys_array_result_drain #(
    parameter int DATA_WIDTH = 8,
    parameter int ARRAY_W    = 5
) (
    input  logic                                                clk,
    input  logic                                                reset_n,
    input  logic                                                res_ready,
    input  logic [0:ARRAY_W-1][0:ARRAY_W-1][2*DATA_WIDTH-1:0]   res_data,
    sys_array_result_drain_if.master                            stream,
    output logic                                                busy,
    output logic                                                overrun
);
    localparam int IDX_W = $clog2(ARRAY_W);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ARRAY_W - 1);

    typedef enum logic {
        IDLE,
        STREAM
    } state_t;

    state_t state;
    state_t next_state;

    logic                                               rdy_q;
    logic [0:ARRAY_W-1][0:ARRAY_W-1][2*DATA_WIDTH-1:0]  res_buf;
    logic [IDX_W-1:0]                                   row;
    logic [IDX_W-1:0]                                   col;

    logic new_res;
    logic hs;
    logic at_last;
    logic load;
    logic advance;
    logic set_ovr;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        load       = 1'b0;
        advance    = 1'b0;
        set_ovr    = 1'b0;
        new_res    = res_ready & ~rdy_q;
        hs         = (state == STREAM) & stream.m_ready;
        at_last    = (row == LAST_IDX) && (col == LAST_IDX);

        case (state)
            IDLE: begin
                if (new_res) begin
                    load       = 1'b1;
                    next_state = STREAM;
                end
            end
            STREAM: begin
                if (hs && at_last) begin
                    // A result landing exactly on the final accepted beat
                    // chains straight into the next stream without a gap.
                    if (new_res) begin
                        load = 1'b1;
                    end else begin
                        next_state = IDLE;
                    end
                end else begin
                    advance = hs;
                    set_ovr = new_res;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // rdy_q resets high so a level already asserted through reset is not
    // mistaken for a fresh result.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rdy_q   <= 1'b1;
            row     <= '0;
            col     <= '0;
            overrun <= 1'b0;
        end else begin
            rdy_q <= res_ready;
            if (set_ovr) begin
                overrun <= 1'b1;
            end
            if (load) begin
                row <= '0;
                col <= '0;
            end else if (advance) begin
                if (col == LAST_IDX) begin
                    col <= '0;
                    row <= row + IDX_W'(1);
                end else begin
                    col <= col + IDX_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (load) begin
            res_buf <= res_data;
        end
    end

    assign busy           = (state == STREAM);
    assign stream.m_valid = busy;
    assign stream.m_data  = busy ? res_buf[row][col] : '0;
    assign stream.m_row   = busy ? row : '0;
    assign stream.m_col   = busy ? col : '0;
    assign stream.m_last  = busy & at_last;
endmodule

// File: tb/tb_sys_array_result_drain.sv
module tb_sys_array_result_drain;
    localparam int DW = 8;
    localparam int W  = 5;

    typedef struct packed {
        logic [15:0] data;
        logic [2:0]  row;
        logic [2:0]  col;
        logic        last;
    } beat_t;

    logic                          clk;
    logic                          reset_n;
    logic                          res_ready;
    logic [0:W-1][0:W-1][2*DW-1:0] res_data;
    logic                          busy;
    logic                          overrun;

    sys_array_result_drain_if #(.DATA_WIDTH(DW), .ARRAY_W(W)) stream_if ();

    sys_array_result_drain #(.DATA_WIDTH(DW), .ARRAY_W(W)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .res_ready (res_ready),
        .res_data  (res_data),
        .stream    (stream_if),
        .busy      (busy),
        .overrun   (overrun)
    );

    int    compared   = 0;
    int    mismatched = 0;
    int    beats      = 0;
    beat_t sb[$];
    logic  prev_stall = 1'b0;
    beat_t held;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic beat_t observed();
        return '{data: stream_if.m_data, row: stream_if.m_row,
                 col: stream_if.m_col, last: stream_if.m_last};
    endfunction

    // Scoreboard consumer and stall-stability monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (reset_n && stream_if.m_valid) begin
            if (prev_stall) begin
                check("stall_hold", 32'(observed()), 32'(held));
            end
            if (stream_if.m_ready) begin
                if (sb.size() == 0) begin
                    check("unexpected_beat", 32'(observed()), 32'hFFFF_FFFF);
                end else begin
                    check("beat", 32'(observed()), 32'(sb.pop_front()));
                end
                beats++;
            end
            prev_stall = !stream_if.m_ready;
            held       = observed();
        end else begin
            prev_stall = 1'b0;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fill(input logic [15:0] base);
        for (int i = 0; i < W; i++)
            for (int j = 0; j < W; j++)
                res_data[i][j] = base + 16'((i << 4) | j);
    endtask

    task automatic push_all();
        for (int i = 0; i < W; i++)
            for (int j = 0; j < W; j++)
                sb.push_back('{data: res_data[i][j], row: 3'(i), col: 3'(j),
                               last: (i == W-1) && (j == W-1)});
    endtask

    // Raise res_ready for one cycle, expecting a capture at that edge.
    task automatic capture();
        res_ready = 1'b0;
        tick();
        res_ready = 1'b1;
        beats = 0;
        push_all();
        tick();
        res_ready = 1'b0;
    endtask

    task automatic drain(output int cycles);
        cycles = 0;
        while (stream_if.m_valid && cycles < 200) begin
            tick();
            cycles++;
        end
        check("drain_end_valid", 32'(stream_if.m_valid), 32'd0);
        check("sb_empty", 32'(sb.size()), 32'd0);
    endtask

    task automatic wait_beats(input int n);
        for (int c = 0; c < 200 && beats < n; c++) tick();
        check("wait_beats", 32'(beats >= n), 32'd1);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
        tick();
    endtask

    initial begin
        int cyc;
        reset_n = 1'b0;
        res_ready = 1'b1;
        stream_if.m_ready = 1'b1;
        fill(16'h0000);

        // 1: reset with res_ready held high, no spurious capture afterwards
        tick();
        tick();
        check("rst_valid", 32'(stream_if.m_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_overrun", 32'(overrun), 32'd0);
        reset_n = 1'b1;
        tick();
        tick();
        tick();
        check("no_capture_valid", 32'(stream_if.m_valid), 32'd0);
        check("no_capture_busy", 32'(busy), 32'd0);

        // 2: basic drain with latency and later res_data changes ignored
        res_ready = 1'b0;
        tick();
        res_ready = 1'b1;
        beats = 0;
        push_all();
        check("pre_edge_valid", 32'(stream_if.m_valid), 32'd0);
        tick();
        res_ready = 1'b0;
        fill(16'hEE00);
        check("latency_valid", 32'(stream_if.m_valid), 32'd1);
        check("first_data", 32'(stream_if.m_data), 32'h0000);
        check("first_busy", 32'(busy), 32'd1);
        drain(cyc);
        check("basic_valid_cycles", 32'(cyc), 32'd25);
        check("idle_data_zero", 32'(observed()), 32'd0);

        // 3: alternating backpressure
        fill(16'h0000);
        capture();
        cyc = 0;
        stream_if.m_ready = 1'b1;
        while (stream_if.m_valid && cyc < 120) begin
            tick();
            cyc++;
            stream_if.m_ready = ~stream_if.m_ready;
        end
        stream_if.m_ready = 1'b1;
        check("bp_valid_cycles", 32'(cyc), 32'd49);
        check("bp_beats", 32'(beats), 32'd25);
        check("bp_sb_empty", 32'(sb.size()), 32'd0);

        // 4: overrun at beat 10, stream continues on original data
        capture();
        wait_beats(10);
        fill(16'h5500);
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        check("overrun_set", 32'(overrun), 32'd1);
        check("overrun_still_valid", 32'(stream_if.m_valid), 32'd1);
        drain(cyc);
        check("overrun_sticky", 32'(overrun), 32'd1);

        // 5: back-to-back capture on the last accepted beat
        do_reset();
        check("overrun_cleared", 32'(overrun), 32'd0);
        fill(16'h0000);
        capture();
        for (int c = 0; c < 60 && !(stream_if.m_valid && stream_if.m_last); c++) tick();
        check("reach_last", 32'(stream_if.m_last), 32'd1);
        fill(16'h3300);
        res_ready = 1'b1;
        push_all();
        tick();
        res_ready = 1'b0;
        check("b2b_valid", 32'(stream_if.m_valid), 32'd1);
        check("b2b_pos", 32'({stream_if.m_row, stream_if.m_col}), 32'd0);
        check("b2b_data", 32'(stream_if.m_data), 32'h3300);
        drain(cyc);
        check("b2b_cycles", 32'(cyc), 32'd25);
        check("b2b_no_overrun", 32'(overrun), 32'd0);

        // 6: reset mid-stream at beat 12
        fill(16'h0000);
        capture();
        wait_beats(12);
        reset_n = 1'b0;
        #1;
        check("async_rst_valid", 32'(stream_if.m_valid), 32'd0);
        check("async_rst_busy", 32'(busy), 32'd0);
        sb.delete();
        #3;
        reset_n = 1'b1;
        tick();
        check("post_rst_valid", 32'(stream_if.m_valid), 32'd0);
        fill(16'h7700);
        capture();
        check("restart_valid", 32'(stream_if.m_valid), 32'd1);
        check("restart_pos", 32'({stream_if.m_row, stream_if.m_col}), 32'd0);
        check("restart_data", 32'(stream_if.m_data), 32'h7700);
        drain(cyc);
        check("restart_cycles", 32'(cyc), 32'd25);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
